// File: rtl/lc3_decode.sv
// LC-3 decode stage: registers the fetched instruction/npc and its execute, writeback and memory controls.
// Optional LC3_DECODE_ILLEGAL_EN flags unsupported opcodes (0100, 1000, 1101, 1111) on the illegal output.
module lc3_decode #(
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable_decode,
  input  logic [DW-1:0] dout,
  input  logic [DW-1:0] npc_in,
  output logic [DW-1:0] ir,
  output logic [DW-1:0] npc_out,
  output logic [5:0]    e_control,
  output logic [1:0]    w_control,
  output logic          mem_control,
  output logic          dec_valid,
  output logic          illegal
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] W_ALU = 2'b00;
  localparam logic [1:0] W_LEA = 2'b01;
  localparam logic [1:0] W_MEM = 2'b10;

  // Opcode and immediate-select bit sit at fixed ISA positions regardless of DW.
  logic [3:0] opcode;
  assign opcode = dout[15:12];

  logic [1:0] alu_next;
  logic [1:0] pcsel1_next;
  logic       pcsel2_next;
  logic       op2_next;
  logic [1:0] w_next;
  logic       mem_next;

  always_comb begin
    alu_next    = 2'b00;
    pcsel1_next = 2'b00;
    pcsel2_next = 1'b0;
    op2_next    = 1'b0;
    w_next      = W_ALU;
    mem_next    = 1'b0;
    case (opcode)
      OP_ADD: op2_next = ~dout[5];
      OP_AND: begin
        alu_next = 2'b01;
        op2_next = ~dout[5];
      end
      OP_NOT: begin
        alu_next = 2'b10;
        op2_next = 1'b1;
      end
      OP_BR, OP_ST: begin
        pcsel1_next = 2'b01;
        pcsel2_next = 1'b1;
      end
      OP_JMP: pcsel1_next = 2'b11;
      OP_LD: begin
        pcsel1_next = 2'b01;
        pcsel2_next = 1'b1;
        w_next      = W_MEM;
      end
      OP_LDR: begin
        pcsel1_next = 2'b10;
        w_next      = W_MEM;
      end
      OP_STR: pcsel1_next = 2'b10;
      OP_LDI: begin
        pcsel1_next = 2'b01;
        pcsel2_next = 1'b1;
        w_next      = W_MEM;
        mem_next    = 1'b1;
      end
      OP_STI: begin
        pcsel1_next = 2'b01;
        pcsel2_next = 1'b1;
        mem_next    = 1'b1;
      end
      OP_LEA: begin
        pcsel1_next = 2'b01;
        pcsel2_next = 1'b1;
        w_next      = W_LEA;
      end
      default: ;  // unsupported opcodes leave every control at zero
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir          <= '0;
      npc_out     <= '0;
      e_control   <= '0;
      w_control   <= '0;
      mem_control <= 1'b0;
      dec_valid   <= 1'b0;
    end else if (enable_decode) begin
      ir          <= dout;
      npc_out     <= npc_in;
      e_control   <= {alu_next, pcsel1_next, pcsel2_next, op2_next};
      w_control   <= w_next;
      mem_control <= mem_next;
      dec_valid   <= 1'b1;
    end
  end

`ifdef LC3_DECODE_ILLEGAL_EN
  localparam logic [15:0] ILLEGAL_MASK = 16'hA110;  // opcodes 4, 8, 13, 15

  logic [15:0] op_onehot;
  logic        illegal_reg;

  for (genvar gi = 0; gi < 16; gi++) begin : g_op_onehot
    assign op_onehot[gi] = (opcode == 4'(gi));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      illegal_reg <= 1'b0;
    end else if (enable_decode) begin
      illegal_reg <= |(op_onehot & ILLEGAL_MASK);
    end
  end

  assign illegal = illegal_reg;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: doc/lc3_decode.md
Name: lc3_decode

Overview:
- Decode stage of the LC-3 pipeline; sits directly downstream of fetch.
- Captures the 16-bit instruction word returned by instruction memory and the fetch-stage npc, then registers the execute, writeback and memory control fields for the execute/memaccess/writeback stages.
- All outputs are registered. Capture is gated by the controller's enable_decode.

Parameters:
- DW, 16, data/address width (instruction, npc); fixed by ISA, not overridable below 16.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable_decode  in  1  capture strobe from controller.
- dout  in  DW  instruction word from instruction memory.
- npc_in  in  DW  pc+1 from fetch, aligned with dout.
- ir  out  DW  registered instruction.
- npc_out  out  DW  registered npc.
- e_control  out  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- w_control  out  2  writeback source select.
- mem_control  out  1  1 = indirect memory op (LDI/STI).
- dec_valid  out  1  outputs hold a decoded instruction.
- illegal  out  1  unsupported opcode captured (see Optional Feature).

Behaviour:
- Reset (async, active-high): all outputs 0 immediately, held 0 while reset=1.
- Capture, on a rising edge with enable_decode=1:
  - ir <= dout, npc_out <= npc_in.
  - Controls are decoded from dout (not from the old ir).
  - dec_valid <= 1.
- Latency: 1 cycle from the enable_decode edge to valid outputs.
- Hold: with enable_decode=0, every output holds, including dec_valid. Stalls never corrupt state.
- Reset mid-operation clears dec_valid. The first capture after reset release sets it.
- Opcode dout[15:12] decode (alu, pcsel1, pcsel2, op2; w_control; mem_control):
  - ADD 0001: 00,00,0,~dout[5]; 00; 0
  - AND 0101: 01,00,0,~dout[5]; 00; 0
  - NOT 1001: 10,00,0,1; 00; 0
  - BR 0000: 00,01,1,0; 00; 0
  - JMP 1100: 00,11,0,0; 00; 0
  - LD 0010: 00,01,1,0; 10; 0
  - LDR 0110: 00,10,0,0; 10; 0
  - LDI 1010: 00,01,1,0; 10; 1
  - LEA 1110: 00,01,1,0; 01; 0
  - ST 0011: 00,01,1,0; 00; 0
  - STR 0111: 00,10,0,0; 00; 0
  - STI 1011: 00,01,1,0; 00; 1
  - Any other opcode: all control fields 0.
- Field encodings:
  - pcselect1: 01 = IR[8:0] offset, 10 = IR[5:0], 11 = zero.
  - pcselect2: 1 = npc, 0 = base register.
  - w_control: 00 = ALU, 01 = LEA pc result, 10 = memory.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: LC3_DECODE_ILLEGAL_EN.
- Defined: opcodes 0100, 1000, 1101 and 1111 captured with enable_decode=1 behave as follows:
  - illegal <= 1, controls forced to 0, ir still captured.
  - illegal clears on the next capture of a legal opcode.
  - illegal resets to 0.
- Undefined: illegal tied to 0. Those opcodes decode to all-zero controls silently.

Test Plan:
- Reset high 20 ns, then dout=0x1283 (ADD R1,R2,R3), npc_in=0x3001, enable=1 -> next edge: ir=0x1283, npc_out=0x3001, e_control=0x01, w=00, mem=0, dec_valid=1.
- dout=0x12A5 (ADD imm) -> e_control=0x00. dout=0x5283 (AND reg) -> 0x11. dout=0x927F (NOT) -> 0x21, w=00.
- Loads/LEA/JMP:
  - dout=0x6943 (LDR) -> e_control=0x08, w=10.
  - dout=0xA005 (LDI) -> e_control=0x06, w=10, mem=1.
  - dout=0xE008 (LEA) -> e_control=0x06, w=01.
  - dout=0xC1C0 (JMP R7) -> e_control=0x0C.
- Stall: capture 0x1283, drop enable 3 cycles while dout=0x6943 -> ir stays 0x1283, controls unchanged. Raise enable -> ir=0x6943 one edge later.
- Async reset mid-stream: assert reset between edges after valid capture -> all outputs 0 before next edge, dec_valid=0, no capture while reset=1.
- With LC3_DECODE_ILLEGAL_EN: dout=0xF025 (TRAP) -> illegal=1, e/w/mem=0, ir=0xF025. Next dout=0x1283 -> illegal=0. Without macro: same stimulus -> illegal=0, controls 0.
